// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of subsystem resets with soft-reset arbitration
module reset_sequencer #(
    parameter int NSTAGE    = 3,
    parameter int NREQ      = 2,
    parameter int HOLD      = 8,
    parameter int STAGE_DLY = 16
) (
    input  logic              baseclk,
    input  logic              asyncrst_n,
    input  logic [NREQ-1:0]   soft_rst_req,
    output logic [NSTAGE-1:0] stage_rst_n,
    output logic              all_ready,
    output logic              busy,
    output logic [NREQ-1:0]   soft_rst_ack,
    output logic [7:0]        seq_count
);

    // Delay counter only has to reach the longer of the two phase lengths minus one.
    localparam int MAXD = (HOLD > STAGE_DLY) ? HOLD : STAGE_DLY;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int IW   = $clog2(NSTAGE + 1);

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;      // number of stages already released
    logic [NSTAGE-1:0] stage_q, stage_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [7:0]        seq_q, seq_d;
    logic [NREQ-1:0]   cur_q, cur_d;      // requesters served by the run in progress
    logic [NREQ-1:0]   nxt_q, nxt_d;      // requesters that arrived too late and wait for the next run

    // State and registered outputs; reset takes effect immediately, independent of the clock.
    always_ff @(posedge baseclk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            ack_q   <= '0;
            seq_q   <= '0;
            cur_q   <= '0;
            nxt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            seq_q   <= seq_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
        end
    end

    // Next-state logic: hold phase, staggered releases, then idle/ack and restart arbitration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        ack_d   = '0;
        seq_d   = seq_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;

        case (state_q)
            ASSERT: begin
                // Late joiners during the hold phase ride along with this run.
                cur_d = cur_q | soft_rst_req;
                if (cnt_q == CW'(HOLD - 1)) begin
                    stage_d = NSTAGE'(1);
                    idx_d   = IW'(1);
                    cnt_d   = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                // Releases are already under way, so new requests need a fresh run.
                nxt_d = nxt_q | soft_rst_req;
                if (cnt_q == CW'(STAGE_DLY - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IW'(NSTAGE)) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        ack_d   = cur_q;
                        if ((|cur_q) && (seq_q != 8'hFF)) begin
                            seq_d = seq_q + 8'd1;
                        end
                        cur_d = '0;
                    end else begin
                        for (int k = 1; k < NSTAGE; k++) begin
                            if (idx_q == IW'(k)) begin
                                stage_d[k] = 1'b1;
                            end
                        end
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // A queued set forces a restart after exactly one idle cycle.
                if (|(nxt_q | soft_rst_req)) begin
                    state_d = ASSERT;
                    stage_d = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    cur_d   = nxt_q | soft_rst_req;
                    nxt_d   = '0;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase
    end

    assign stage_rst_n  = stage_q;
    assign all_ready    = ready_q;
    assign busy         = busy_q;
    assign soft_rst_ack = ack_q;
    assign seq_count    = seq_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
module tb_reset_sequencer;

    logic       baseclk;
    logic       asyncrst_n;
    logic [1:0] soft_rst_req;
    logic [2:0] stage_rst_n;
    logic       all_ready;
    logic       busy;
    logic [1:0] soft_rst_ack;
    logic [7:0] seq_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       rdy;
        logic       bsy;
        logic [1:0] ack;
        logic [7:0] seq;
    } exp_t;

    exp_t q[$];

    reset_sequencer #(.NSTAGE(3), .NREQ(2), .HOLD(8), .STAGE_DLY(16)) dut (
        .baseclk      (baseclk),
        .asyncrst_n   (asyncrst_n),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (stage_rst_n),
        .all_ready    (all_ready),
        .busy         (busy),
        .soft_rst_ack (soft_rst_ack),
        .seq_count    (seq_count)
    );

    initial baseclk = 1'b0;
    always #5 baseclk = ~baseclk;

    always @(posedge baseclk) cyc <= cyc + 1;

    // Compare scoreboard entries due at the edge just passed.
    always @(negedge baseclk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            checks++;
            if (q[0].cyc < cyc) begin
                errors++;
                $display("FAIL stale_entry edge=%0d now=%0d", q[0].cyc, cyc);
            end else if ({stage_rst_n, all_ready, busy, soft_rst_ack, seq_count} !==
                         {q[0].st, q[0].rdy, q[0].bsy, q[0].ack, q[0].seq}) begin
                errors++;
                $display("FAIL edge%0d got stage=%b rdy=%b busy=%b ack=%b seq=%0d want stage=%b rdy=%b busy=%b ack=%b seq=%0d",
                         cyc, stage_rst_n, all_ready, busy, soft_rst_ack, seq_count,
                         q[0].st, q[0].rdy, q[0].bsy, q[0].ack, q[0].seq);
            end
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge baseclk);
        #2;
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic rdy, input logic bsy,
                        input logic [1:0] ack, input logic [7:0] seq);
        exp_t e;
        e.cyc = c; e.st = st; e.rdy = rdy; e.bsy = bsy; e.ack = ack; e.seq = seq;
        q.push_back(e);
    endtask

    // Expected timeline of one run starting at edge e (releases at 8/24/40, done at 56).
    task automatic push_run(input int e, input logic [1:0] a, input logic [7:0] s0,
                            input logic [7:0] s1, input bit idle_after);
        push(e,      3'b000, 1'b0, 1'b1, 2'b00, s0);
        push(e + 7,  3'b000, 1'b0, 1'b1, 2'b00, s0);
        push(e + 8,  3'b001, 1'b0, 1'b1, 2'b00, s0);
        push(e + 23, 3'b001, 1'b0, 1'b1, 2'b00, s0);
        push(e + 24, 3'b011, 1'b0, 1'b1, 2'b00, s0);
        push(e + 39, 3'b011, 1'b0, 1'b1, 2'b00, s0);
        push(e + 40, 3'b111, 1'b0, 1'b1, 2'b00, s0);
        push(e + 55, 3'b111, 1'b0, 1'b1, 2'b00, s0);
        push(e + 56, 3'b111, 1'b1, 1'b0, a,     s1);
        if (idle_after) push(e + 57, 3'b111, 1'b1, 1'b0, 2'b00, s1);
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (q.size() != 0 && n < 20000) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout pending=%0d got=%0d want=0", name, q.size(), q.size());
            q.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc < target && n < 20000) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if ({stage_rst_n, all_ready, busy, soft_rst_ack, seq_count} !== {3'b000, 1'b0, 1'b1, 2'b00, 8'd0}) begin
            errors++;
            $display("FAIL %s got stage=%b rdy=%b busy=%b ack=%b seq=%0d want 000/0/1/00/0",
                     name, stage_rst_n, all_ready, busy, soft_rst_ack, seq_count);
        end
    endtask

    task automatic test_reset();
        asyncrst_n   = 1'b0;
        soft_rst_req = 2'b00;
        repeat (5) tick();
        check_reset_vals("reset_values");
    endtask

    task automatic test_power_on();
        asyncrst_n = 1'b1;
        push_run(cyc, 2'b00, 8'd0, 8'd0, 1'b1);
        wait_empty("power_on");
    endtask

    task automatic test_single();
        int e;
        tick();
        e = cyc + 1;
        soft_rst_req = 2'b01;
        push_run(e, 2'b01, 8'd0, 8'd1, 1'b1);
        tick();
        soft_rst_req = 2'b00;
        wait_empty("single");
    endtask

    task automatic test_merge();
        int e;
        tick();
        e = cyc + 1;
        soft_rst_req = 2'b01;
        push_run(e, 2'b11, 8'd1, 8'd2, 1'b1);
        tick();
        soft_rst_req = 2'b00;
        wait_cyc(e + 2);
        soft_rst_req = 2'b10;
        tick();
        soft_rst_req = 2'b00;
        wait_empty("merge");
    endtask

    task automatic test_queue();
        int e;
        tick();
        e = cyc + 1;
        soft_rst_req = 2'b01;
        push_run(e, 2'b01, 8'd2, 8'd3, 1'b0);
        push_run(e + 57, 2'b10, 8'd3, 8'd4, 1'b1);
        tick();
        soft_rst_req = 2'b00;
        wait_cyc(e + 29);
        soft_rst_req = 2'b10;
        tick();
        soft_rst_req = 2'b00;
        wait_empty("queue");
    endtask

    task automatic test_reset_mid_run();
        int e;
        tick();
        e = cyc + 1;
        soft_rst_req = 2'b01;
        push_run(e, 2'b01, 8'd4, 8'd5, 1'b1);
        tick();
        soft_rst_req = 2'b00;
        wait_cyc(e + 30);
        asyncrst_n = 1'b0;
        #1;
        q.delete();
        check_reset_vals("mid_run_async");
        repeat (3) tick();
        check_reset_vals("mid_run_hold");
        asyncrst_n = 1'b1;
        push_run(cyc, 2'b00, 8'd0, 8'd0, 1'b1);
        wait_empty("mid_run_repower");
    endtask

    task automatic test_saturation();
        int e;
        int s;
        tick();
        e = cyc + 1;
        soft_rst_req = 2'b01;
        for (int k = 0; k < 260; k++) begin
            s = (k + 1 > 255) ? 255 : k + 1;
            push_run(e + 57 * k, 2'b01, 8'((k > 255) ? 255 : k), 8'(s), k == 259);
        end
        wait_cyc(e + 57 * 259 + 2);
        soft_rst_req = 2'b00;
        wait_empty("saturation");
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_single();
        test_merge();
        test_queue();
        test_reset_mid_run();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
